airi5c_pre_normalizer_pipe: RTL and testbench

//  Parametrised, pipelined FPU operand pre-normalizer: unpacks CH raw IEEE-754 operands, classifies them,

---
 rtl/airi5c_pre_normalizer_pipe_pkg.sv | 32 +++
 rtl/airi5c_pre_normalizer_pipe_lzc.sv | 22 ++
 rtl/airi5c_pre_normalizer_pipe.sv | 138 +++++++++++++
 tb/tb_airi5c_pre_normalizer_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/airi5c_pre_normalizer_pipe_pkg.sv
// rtl/airi5c_pre_normalizer_pipe_pkg.sv - FPU operand class indices, format widths and classifier
package airi5c_pre_normalizer_pipe_pkg;

   localparam int CLS_ZERO = 0;
   localparam int CLS_DEN  = 1;
   localparam int CLS_INF  = 2;
   localparam int CLS_QNAN = 3;
   localparam int CLS_SNAN = 4;
   localparam int CLS_W    = 5;

   localparam int HALF_EXP_W    = 5;
   localparam int HALF_FRAC_W   = 10;
   localparam int SINGLE_EXP_W  = 8;
   localparam int SINGLE_FRAC_W = 23;
   localparam int DOUBLE_EXP_W  = 11;
   localparam int DOUBLE_FRAC_W = 52;

   // man_zero covers the whole mantissa including the hidden bit, so it is only set for true zeros
   function automatic logic [CLS_W-1:0] classify(input logic man_zero, input logic exp_zero,
                                                 input logic exp_max, input logic frac_zero,
                                                 input logic frac_msb);
      logic [CLS_W-1:0] c;
      c           = '0;
      c[CLS_ZERO] = man_zero;
      c[CLS_DEN]  = exp_zero && !man_zero;
      c[CLS_INF]  = exp_max && frac_zero;
      c[CLS_QNAN] = exp_max && !frac_zero && frac_msb;
      c[CLS_SNAN] = exp_max && !frac_zero && !frac_msb;
      return c;
   endfunction

endpackage

// File: rtl/airi5c_pre_normalizer_pipe_lzc.sv
// rtl/airi5c_pre_normalizer_pipe_lzc.sv - parametrised leading-zero counter
module airi5c_lzc_param #(
   parameter int W = 24
) (
   input  logic [W-1:0]             in,
   output logic [$clog2(W+1)-1:0]   y,
   output logic                     all_zero
);

   localparam int YW = $clog2(W+1);

   // scanning upward lets the highest set bit overwrite lower ones
   always_comb begin
      y = YW'(W);
      for (int i = 0; i < W; i++) begin
         if (in[i]) y = YW'(W - 1 - i);
      end
   end

   assign all_zero = ~|in;

endmodule

// File: rtl/airi5c_pre_normalizer_pipe.sv
// rtl/airi5c_pre_normalizer_pipe.sv - two-stage FPU operand unpack, classify and normalize pipeline
module airi5c_pre_normalizer_pipe
   import airi5c_pre_normalizer_pipe_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   parameter int CH     = 2
) (
   input  logic                      clk,
   input  logic                      n_reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CH-1:0]             in_sign,
   input  logic [CH*EXP_W-1:0]       in_exp,
   input  logic [CH*FRAC_W-1:0]      in_frac,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CH-1:0]             out_sign,
   output logic [CH*(FRAC_W+1)-1:0]  out_man,
   output logic [CH*(EXP_W+2)-1:0]   out_exp,
   output logic [CH*5-1:0]           out_class
);

   localparam int MAN_W  = FRAC_W + 1;
   localparam int OEXP_W = EXP_W + 2;
   localparam int LZ_W   = $clog2(MAN_W + 1);
   localparam logic [OEXP_W-1:0] BIAS    = OEXP_W'((2 ** (EXP_W - 1)) - 1);
   localparam logic [OEXP_W-1:0] DEN_EXP = OEXP_W'(1) - BIAS;

   logic s1_valid;
   logic s2_adv;
   logic s1_load;
   logic s2_load;

   // out_valid doubles as the S2 valid; a flush also refuses the same-cycle input
   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !flush && (!s1_valid || s2_adv);
   assign s1_load  = in_valid && in_ready;
   assign s2_load  = s1_valid && s2_adv && !flush;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else if (flush) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (s2_adv)   out_valid <= s1_valid;
         if (in_ready) s1_valid  <= in_valid;
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [EXP_W-1:0]  exp_f;
      logic [FRAC_W-1:0] frac_f;
      logic [MAN_W-1:0]  man_in;
      logic [LZ_W-1:0]   lz;
      logic              man_zero;
      logic [CLS_W-1:0]  cls_in;

      logic              s1_sign;
      logic [MAN_W-1:0]  s1_man;
      logic [LZ_W-1:0]   s1_lz;
      logic [CLS_W-1:0]  s1_cls;
      logic [EXP_W-1:0]  s1_exp_f;

      logic [MAN_W-1:0]  man_n;
      logic [OEXP_W-1:0] exp_n;

      logic              o_sign;
      logic [MAN_W-1:0]  o_man;
      logic [OEXP_W-1:0] o_exp;
      logic [CLS_W-1:0]  o_cls;

      assign exp_f  = in_exp[i*EXP_W +: EXP_W];
      assign frac_f = in_frac[i*FRAC_W +: FRAC_W];
      assign man_in = {|exp_f, frac_f};

      airi5c_lzc_param #(.W(MAN_W)) u_lzc (
         .in       (man_in),
         .y        (lz),
         .all_zero (man_zero)
      );

      assign cls_in = classify(man_zero, ~|exp_f, &exp_f, ~|frac_f, frac_f[FRAC_W-1]);

      always_ff @(posedge clk or negedge n_reset) begin
         if (!n_reset) begin
            s1_sign  <= 1'b0;
            s1_man   <= '0;
            s1_lz    <= '0;
            s1_cls   <= '0;
            s1_exp_f <= '0;
         end else if (s1_load) begin
            s1_sign  <= in_sign[i];
            s1_man   <= man_in;
            s1_lz    <= lz;
            s1_cls   <= cls_in;
            s1_exp_f <= exp_f;
         end
      end

      // inf/nan share the normal path: EMAX - BIAS falls out of the same subtraction
      always_comb begin
         man_n = s1_man;
         exp_n = OEXP_W'(s1_exp_f) - BIAS;
         if (s1_cls[CLS_ZERO]) begin
            man_n = '0;
            exp_n = '0;
         end else if (s1_cls[CLS_DEN]) begin
            man_n = s1_man << s1_lz;
            exp_n = DEN_EXP - OEXP_W'(s1_lz);
         end
      end

      always_ff @(posedge clk or negedge n_reset) begin
         if (!n_reset) begin
            o_sign <= 1'b0;
            o_man  <= '0;
            o_exp  <= '0;
            o_cls  <= '0;
         end else if (s2_load) begin
            o_sign <= s1_sign;
            o_man  <= man_n;
            o_exp  <= exp_n;
            o_cls  <= s1_cls;
         end
      end

      assign out_sign[i]                    = o_sign;
      assign out_man[i*MAN_W +: MAN_W]      = o_man;
      assign out_exp[i*OEXP_W +: OEXP_W]    = o_exp;
      assign out_class[i*CLS_W +: CLS_W]    = o_cls;
   end

endmodule

// File: tb/tb_airi5c_pre_normalizer_pipe.sv
// tb/tb_airi5c_pre_normalizer_pipe.sv - scoreboard bench for the operand pre-normalizer pipeline
module tb_airi5c_pre_normalizer_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic        in_ready;
   logic        out_valid;
   logic [1:0]  in_sign = '0;
   logic [15:0] in_exp = '0;
   logic [45:0] in_frac = '0;
   logic [1:0]  out_sign;
   logic [47:0] out_man;
   logic [19:0] out_exp;
   logic [9:0]  out_class;

   logic        d_rst_n = 1'b0;
   logic        d_in_valid = 1'b0;
   logic        d_in_ready;
   logic        d_out_valid;
   logic [0:0]  d_in_sign = '0;
   logic [10:0] d_in_exp = '0;
   logic [51:0] d_in_frac = '0;
   logic [0:0]  d_out_sign;
   logic [52:0] d_out_man;
   logic [12:0] d_out_exp;
   logic [4:0]  d_out_class;

   always #5 clk = ~clk;

   airi5c_pre_normalizer_pipe #(.EXP_W(8), .FRAC_W(23), .CH(2)) dut (
      .clk(clk), .n_reset(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac), .out_valid(out_valid),
      .out_ready(out_ready), .out_sign(out_sign), .out_man(out_man), .out_exp(out_exp),
      .out_class(out_class)
   );

   airi5c_pre_normalizer_pipe #(.EXP_W(11), .FRAC_W(52), .CH(1)) dut_d (
      .clk(clk), .n_reset(d_rst_n), .flush(1'b0), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .in_sign(d_in_sign), .in_exp(d_in_exp), .in_frac(d_in_frac), .out_valid(d_out_valid),
      .out_ready(1'b1), .out_sign(d_out_sign), .out_man(d_out_man), .out_exp(d_out_exp),
      .out_class(d_out_class)
   );

   typedef struct packed {
      logic [1:0]  s;
      logic [47:0] m;
      logic [19:0] e;
      logic [9:0]  c;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   pushed = 0;
   int   popped = 0;
   logic waited = 1'b0;

   function automatic exp_t mk(input logic s1, input logic s0, input logic [23:0] m1,
                               input logic [23:0] m0, input logic [9:0] e1, input logic [9:0] e0,
                               input logic [4:0] c1, input logic [4:0] c0);
      exp_t x;
      x.s = {s1, s0};
      x.m = {m1, m0};
      x.e = {e1, e0};
      x.c = {c1, c0};
      return x;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   task automatic send(input logic [31:0] w0, input logic [31:0] w1, input exp_t x);
      @(negedge clk);
      in_valid = 1'b1;
      in_sign  = {w1[31], w0[31]};
      in_exp   = {w1[30:23], w0[30:23]};
      in_frac  = {w1[22:0], w0[22:0]};
      for (int n = 0; n < 50; n++) begin
         #4;
         if (in_ready) begin
            sb.push_back(x);
            pushed++;
            @(posedge clk);
            return;
         end
         waited = 1'b1;
         @(negedge clk);
      end
      timeout("send");
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic latency(input string nm);
      #4;
      chk({nm, "_lat1"}, 128'(out_valid), 128'(1'b0));
      @(negedge clk);
      #4;
      chk({nm, "_lat2"}, 128'(out_valid), 128'(1'b1));
   endtask

   task automatic drain();
      for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
      chk("drain", 128'(sb.size()), 128'(0));
   endtask

   initial begin : monitor
      exp_t cur;
      exp_t prev;
      exp_t x;
      logic stall;
      stall = 1'b0;
      prev  = '0;
      forever begin
         @(negedge clk);
         #4;
         cur = {out_sign, out_man, out_exp, out_class};
         if (stall && out_valid) chk("hold", cur, prev);
         stall = out_valid && !out_ready;
         prev  = cur;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output actual=%0h required=none", cur);
            end else begin
               x = sb.pop_front();
               popped++;
               chk("data", cur, x);
            end
         end
      end
   end

   initial begin : stim
      logic found;
      repeat (3) @(negedge clk);
      rst_n   = 1'b1;
      d_rst_n = 1'b1;
      #4;
      chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
      chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst_out_data", {out_sign, out_man, out_exp, out_class}, 128'(0));

      // 1.0 and +0, then latency from an empty pipe
      send(32'h3F80_0000, 32'h0000_0000,
           mk(0, 0, 24'h0, 24'h80_0000, 10'h000, 10'h000, 5'b00001, 5'b00000));
      idle();
      latency("t1");
      // smallest denormal and 2^-127 denormal
      send(32'h0000_0001, 32'h0040_0000,
           mk(0, 0, 24'h80_0000, 24'h80_0000, 10'h381, 10'h36B, 5'b00010, 5'b00010));
      // inf / qnan, then snan / 1.0
      send(32'h7F80_0000, 32'h7FC0_0000,
           mk(0, 0, 24'hC0_0000, 24'h80_0000, 10'h080, 10'h080, 5'b01000, 5'b00100));
      send(32'h7F80_0001, 32'h3F80_0000,
           mk(0, 0, 24'h80_0000, 24'h80_0001, 10'h000, 10'h080, 5'b00000, 5'b10000));
      idle();
      drain();

      // back-to-back stream with a 3-cycle output stall
      waited = 1'b0;
      fork
         begin
            send(32'h4000_0000, 32'hBF80_0000,
                 mk(1, 0, 24'h80_0000, 24'h80_0000, 10'h000, 10'h001, 5'b00000, 5'b00000));
            send(32'h0000_0002, 32'h8000_0000,
                 mk(1, 0, 24'h00_0000, 24'h80_0000, 10'h000, 10'h36C, 5'b00001, 5'b00010));
            send(32'h3FC0_0000, 32'h0060_0000,
                 mk(0, 0, 24'hC0_0000, 24'hC0_0000, 10'h381, 10'h000, 5'b00010, 5'b00000));
            send(32'h7F7F_FFFF, 32'h0080_0000,
                 mk(0, 0, 24'h80_0000, 24'hFF_FFFF, 10'h382, 10'h07F, 5'b00000, 5'b00000));
            idle();
         end
         begin
            repeat (2) @(negedge clk);
            out_ready = 1'b0;
            repeat (3) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      chk("t4_in_ready_dropped", 128'(waited), 128'(1'b1));
      drain();

      // flush with two sets in flight and a competing input
      @(negedge clk);
      out_ready = 1'b0;
      send(32'h3F80_0000, 32'h3F80_0000,
           mk(0, 0, 24'h80_0000, 24'h80_0000, 10'h000, 10'h000, 5'b00000, 5'b00000));
      send(32'h4000_0000, 32'h4000_0000,
           mk(0, 0, 24'h80_0000, 24'h80_0000, 10'h001, 10'h001, 5'b00000, 5'b00000));
      @(negedge clk);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_sign  = 2'b11;
      in_exp   = {8'h7F, 8'h80};
      in_frac  = '0;
      #4;
      chk("t5_in_ready_flush", 128'(in_ready), 128'(1'b0));
      @(negedge clk);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      pushed   -= sb.size();
      sb.delete();
      #4;
      chk("t5_out_valid", 128'(out_valid), 128'(1'b0));
      send(32'h4040_0000, 32'hC000_0000,
           mk(1, 0, 24'h80_0000, 24'hC0_0000, 10'h001, 10'h001, 5'b00000, 5'b00000));
      idle();
      latency("t5");
      drain();
      chk("count", 128'(popped), 128'(pushed));

      // double precision, single channel
      @(negedge clk);
      d_in_valid = 1'b1;
      d_in_sign  = 1'b0;
      d_in_exp   = '0;
      d_in_frac  = 52'h1;
      @(negedge clk);
      d_in_valid = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 10; n++) begin
         #4;
         if (d_out_valid) begin
            found = 1'b1;
            chk("t6_man", 128'(d_out_man), 128'(53'h1) << 52);
            chk("t6_exp", 128'(d_out_exp), 128'(13'h1BCE));
            chk("t6_class", 128'(d_out_class), 128'(5'b00010));
            break;
         end
         @(negedge clk);
      end
      if (!found) timeout("t6_out_valid");

      @(negedge clk);
      d_in_valid = 1'b1;
      @(negedge clk);
      d_in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_valid_before_reset", 128'(d_out_valid), 128'(1'b1));
      d_rst_n = 1'b0;
      #1;
      chk("t6_valid_in_reset", 128'(d_out_valid), 128'(1'b0));
      chk("t6_man_in_reset", 128'(d_out_man), 128'(0));
      @(negedge clk);
      d_rst_n = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
